// File: rtl/lfsr_decrypt_seq_pkg.sv
// rtl/lfsr_decrypt_seq_pkg.sv - shared types, tap table and LFSR step for the decrypt sequencer
// Contents: state_e (sequencer states), NUM_PTRN, LFSR_PTRN (legal 7-bit tap
// patterns in index order), lfsr_step (one Fibonacci step), ptrn_at (safe lookup).
package decrypt_pkg;

    localparam int NUM_PTRN = 9;

    localparam logic [6:0] LFSR_PTRN [NUM_PTRN] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEED_RD  = 3'd1,
        ST_SEED_CAP = 3'd2,
        ST_CHK_RD   = 3'd3,
        ST_CHK_CMP  = 3'd4,
        ST_DEC_RD   = 3'd5,
        ST_DEC_WR   = 3'd6,
        ST_DONE     = 3'd7
    } state_e;

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] ptrn);
        return {s[5:0], ^(s & ptrn)};
    endfunction

    // Out-of-range indices return 0 so speculative lookups (p+1 at p==8) stay defined.
    function automatic logic [6:0] ptrn_at(input logic [3:0] idx);
        logic [6:0] t;
        t = 7'h00;
        for (int n = 0; n < NUM_PTRN; n++) begin
            if (idx == 4'(n)) t = LFSR_PTRN[n];
        end
        return t;
    endfunction

endpackage

// File: rtl/lfsr_decrypt_seq_if.sv
// rtl/lfsr_decrypt_seq_if.sv - data-memory port bundle between the sequencer and DM
// Signals: mem_addr (AW), mem_we, mem_wdata (8), mem_rdata (8, valid one cycle
// after mem_addr). master = sequencer side, slave = memory side.
interface lfsr_decrypt_seq_if #(
    parameter int AW = 8
);
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lfsr_decrypt_seq_lfsr7.sv
// rtl/lfsr_decrypt_seq_lfsr7.sv - 7-bit LFSR register with load and step controls
// Ports: clk, rst (async active-high), load/load_val (load has priority),
// step/ptrn (advance one step using tap pattern ptrn), q (current state).
module lfsr7
    import decrypt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       step,
    input  logic [6:0] ptrn,
    output logic [6:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 7'h00;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= lfsr_step(q, ptrn);
        end
    end

endmodule

// File: rtl/lfsr_decrypt_seq.sv
// rtl/lfsr_decrypt_seq.sv - sequencer recovering LFSR seed/pattern and decrypting into DM[0..MSG_LEN-1]
// Ports: clk; init (async active-high reset); req (high holds idle, falling edge
// launches); ack (run complete, held until req high); mem (lfsr_decrypt_seq_if.master
// DM port); err (no valid seed or pattern); ptrn_idx (matched pattern index, 4'hF if none);
// par_err (sticky bit-7 parity error, present only with DECRYPT_PARITY_EN).
// Optional build macro: DECRYPT_PARITY_EN.
module lfsr_decrypt_seq
    import decrypt_pkg::*;
#(
    parameter int CRYPT_BASE = 64,
    parameter int MSG_LEN    = 64,
    parameter int PRE_CHECK  = 9,
    parameter int AW         = 8
) (
    input  logic               clk,
    input  logic               init,
    input  logic               req,
    output logic               ack,
    lfsr_decrypt_seq_if.master mem,
    output logic               err,
    output logic [3:0]         ptrn_idx
`ifdef DECRYPT_PARITY_EN
    ,
    output logic               par_err
`endif
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_SEED_RD  = ST_SEED_RD;
    localparam logic [2:0] S_SEED_CAP = ST_SEED_CAP;
    localparam logic [2:0] S_CHK_RD   = ST_CHK_RD;
    localparam logic [2:0] S_CHK_CMP  = ST_CHK_CMP;
    localparam logic [2:0] S_DEC_RD   = ST_DEC_RD;
    localparam logic [2:0] S_DEC_WR   = ST_DEC_WR;
    localparam logic [2:0] S_DONE     = ST_DONE;

    localparam logic [AW-1:0] BASE   = AW'(CRYPT_BASE);
    localparam logic [AW-1:0] LAST_I = AW'(MSG_LEN - 1);
    localparam logic [3:0]    LAST_K = 4'(PRE_CHECK);
    localparam logic [3:0]    LAST_P = 4'(NUM_PTRN - 1);

    if (CRYPT_BASE + MSG_LEN - 1 > (1 << AW) - 1) begin : g_addr_range_chk
        $error("CRYPT_BASE+MSG_LEN-1 does not fit in the AW-bit DM address space");
    end

    logic [2:0]    state;
    logic          req_q;
    logic [6:0]    seed;
    logic [3:0]    p;
    logic [3:0]    k;
    logic [AW-1:0] i;

    logic          lf_load;
    logic          lf_step;
    logic [6:0]    lf_val;
    logic [6:0]    lf_ptrn;
    logic [6:0]    lfsr_q;

    logic [6:0]    rd7;
    logic          chk_match;
    logic          seed_bad;

    assign rd7       = mem.mem_rdata[6:0];
    assign chk_match = (rd7 == lfsr_q);

`ifdef DECRYPT_PARITY_EN
    logic rd_par_bad;
    assign rd_par_bad = mem.mem_rdata[7] != ^rd7;
    assign seed_bad   = (rd7 == 7'h00) || rd_par_bad;
`else
    // Bit 7 of the encrypted stream carries no information in this build.
    logic unused_rd_b7;
    assign unused_rd_b7 = mem.mem_rdata[7];
    assign seed_bad     = (rd7 == 7'h00);
`endif

    lfsr7 u_lfsr (
        .clk      (clk),
        .rst      (init),
        .load     (lf_load),
        .load_val (lf_val),
        .step     (lf_step),
        .ptrn     (lf_ptrn),
        .q        (lfsr_q)
    );

    // DM port and LFSR controls are decoded from the current state. Memory read
    // data for an address driven in an *_RD state is consumed in the following state.
    always_comb begin
        lf_load       = 1'b0;
        lf_step       = 1'b0;
        lf_val        = seed;
        lf_ptrn       = ptrn_at(p);
        mem.mem_addr  = '0;
        mem.mem_we    = 1'b0;
        mem.mem_wdata = 8'h00;
        case (state)
            S_SEED_RD: begin
                mem.mem_addr = BASE;
            end
            S_SEED_CAP: begin
                // Preload the expected preamble byte 1 for the first candidate.
                lf_load = 1'b1;
                lf_val  = lfsr_step(rd7, ptrn_at(4'd0));
            end
            S_CHK_RD: begin
                mem.mem_addr = BASE + AW'(k);
            end
            S_CHK_CMP: begin
                if (chk_match) begin
                    if (k == LAST_K) begin
                        lf_load = 1'b1;          // rewind to seed for decryption
                    end else begin
                        lf_step = 1'b1;
                    end
                end else if (p < LAST_P) begin
                    lf_load = 1'b1;
                    lf_val  = lfsr_step(seed, ptrn_at(p + 4'd1));
                end
            end
            S_DEC_RD: begin
                mem.mem_addr = BASE + i;
            end
            S_DEC_WR: begin
                mem.mem_addr  = i;
                mem.mem_we    = !req;            // an abort cycle must not write
                mem.mem_wdata = {1'b0, rd7 ^ lfsr_q};
                lf_step       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state    <= S_IDLE;
            req_q    <= 1'b0;
            seed     <= 7'h00;
            p        <= 4'd0;
            k        <= 4'd0;
            i        <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            ptrn_idx <= 4'hF;
`ifdef DECRYPT_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            req_q <= req;
            if (req && state != S_IDLE) begin
                // req high outside IDLE is both the abort and the DONE release.
                state <= S_IDLE;
                ack   <= 1'b0;
                err   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req_q && !req) begin
                            state    <= S_SEED_RD;
                            ack      <= 1'b0;
                            err      <= 1'b0;
                            ptrn_idx <= 4'hF;
                            p        <= 4'd0;
                            k        <= 4'd0;
                            i        <= '0;
`ifdef DECRYPT_PARITY_EN
                            par_err  <= 1'b0;
`endif
                        end
                    end
                    S_SEED_RD: begin
                        state <= S_SEED_CAP;
                    end
                    S_SEED_CAP: begin
                        seed <= rd7;
                        if (seed_bad) begin
                            err   <= 1'b1;
                            ack   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            p     <= 4'd0;
                            k     <= 4'd1;
                            state <= S_CHK_RD;
                        end
                    end
                    S_CHK_RD: begin
                        state <= S_CHK_CMP;
                    end
                    S_CHK_CMP: begin
                        if (chk_match) begin
                            if (k == LAST_K) begin
                                ptrn_idx <= p;
                                i        <= '0;
                                state    <= S_DEC_RD;
                            end else begin
                                k     <= k + 4'd1;
                                state <= S_CHK_RD;
                            end
                        end else if (p < LAST_P) begin
                            p     <= p + 4'd1;
                            k     <= 4'd1;
                            state <= S_CHK_RD;
                        end else begin
                            err      <= 1'b1;
                            ack      <= 1'b1;
                            ptrn_idx <= 4'hF;
                            state    <= S_DONE;
                        end
                    end
                    S_DEC_RD: begin
                        state <= S_DEC_WR;
                    end
                    S_DEC_WR: begin
`ifdef DECRYPT_PARITY_EN
                        if (rd_par_bad) par_err <= 1'b1;
`endif
                        if (i == LAST_I) begin
                            ack   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            i     <= i + AW'(1);
                            state <= S_DEC_RD;
                        end
                    end
                    S_DONE: begin
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt_seq.sv
// tb/tb_lfsr_decrypt_seq.sv - self-checking bench for lfsr_decrypt_seq against a message-level model
module tb_lfsr_decrypt_seq;

    logic       clk  = 1'b0;
    logic       init = 1'b1;
    logic       req  = 1'b0;
    logic       ack;
    logic       err;
    logic [3:0] ptrn_idx;
`ifdef DECRYPT_PARITY_EN
    logic       par_err;
`endif

    lfsr_decrypt_seq_if #(.AW(8)) bus ();

    lfsr_decrypt_seq dut (
        .clk      (clk),
        .init     (init),
        .req      (req),
        .ack      (ack),
        .mem      (bus),
        .err      (err),
        .ptrn_idx (ptrn_idx)
`ifdef DECRYPT_PARITY_EN
        ,
        .par_err  (par_err)
`endif
    );

    always #5 clk = ~clk;

    // Data memory: synchronous read, bulk preload from img[] when do_load is high.
    logic [7:0] dm  [256];
    logic [7:0] img [256];
    logic       do_load = 1'b0;
    int         wr_cnt  = 0;

    always @(posedge clk) begin
        if (do_load) begin
            for (int a = 0; a < 256; a++) dm[a] <= img[a];
        end else if (bus.mem_we) begin
            dm[bus.mem_addr] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        bus.mem_rdata <= dm[bus.mem_addr];
    end

    int         taps [9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};
    logic [7:0] plain  [64];
    logic [7:0] enc    [64];
    logic [7:0] exp_dm [64];
    int         exp_idx, exp_err, exp_lat;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Next keystream value: shift left within 7 bits, append parity of tapped bits.
    function automatic int nxt(input int s, input int t);
        return ((s * 2) % 128) + ($countones(s & t) % 2);
    endfunction

    task automatic set_preamble();
        for (int n = 0; n < 64; n++) plain[n] = 8'h20;
    endtask

    // Encrypt plain[] (ASCII) as space-relative bytes XOR keystream from seed.
    task automatic build(input int q, input int seed);
        int s, pl;
        s = seed;
        for (int n = 0; n < 64; n++) begin
            pl = int'(plain[n]) - 'h20;
            enc[n][6:0] = 7'(pl ^ s);
`ifdef DECRYPT_PARITY_EN
            enc[n][7] = ^enc[n][6:0];
`else
            enc[n][7] = 1'($urandom_range(0, 1));
`endif
            s = nxt(s, taps[q]);
        end
    endtask

    // Decide what a correct sequencer must produce for enc[] and img[0..63].
    task automatic model();
        int  seed, s, cmp;
        bit  ok;
        seed    = int'(enc[0][6:0]);
        exp_idx = 15;
        exp_err = 1;
        cmp     = 0;
        for (int n = 0; n < 64; n++) exp_dm[n] = img[n];
        if (seed == 0) begin
            exp_lat = 2;
            return;
        end
        for (int q = 0; q < 9 && exp_err != 0; q++) begin
            s  = seed;
            ok = 1'b1;
            for (int kk = 1; kk <= 9 && ok; kk++) begin
                s = nxt(s, taps[q]);
                cmp++;
                if (int'(enc[kk][6:0]) != s) ok = 1'b0;
            end
            if (ok) begin
                exp_idx = q;
                exp_err = 0;
            end
        end
        if (exp_err != 0) begin
            exp_lat = 2 + 2 * cmp;
            return;
        end
        s = seed;
        for (int n = 0; n < 64; n++) begin
            exp_dm[n] = 8'(int'(enc[n][6:0]) ^ s);
            s = nxt(s, taps[exp_idx]);
        end
        exp_lat = 2 + 2 * cmp + 128;
    endtask

    task automatic prep();
        for (int a = 0; a < 256; a++) img[a] = 8'($urandom);
        for (int n = 0; n < 64; n++) img[64 + n] = enc[n];
        @(negedge clk); do_load = 1'b1;
        @(negedge clk); do_load = 1'b0;
        model();
    endtask

    // Launch a run, wait (bounded) for ack, and compare everything with the model.
    task automatic run(input string name, input int budget, output int lat);
        int w0;
        w0 = wr_cnt;
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < budget);
        check({name, " ack"},      32'(ack), 1);
        check({name, " latency"},  lat, exp_lat);
        check({name, " err"},      32'(err), exp_err);
        check({name, " ptrn_idx"}, 32'(ptrn_idx), exp_idx);
        check({name, " writes"},   wr_cnt - w0, (exp_err != 0) ? 0 : 64);
`ifdef DECRYPT_PARITY_EN
        check({name, " par_err"},  32'(par_err), 0);
`endif
        repeat (3) @(negedge clk);
        check({name, " ack held"}, 32'(ack), 1);
        for (int n = 0; n < 64; n++)
            check($sformatf("%s dm[%0d]", name, n), 32'(dm[n]), 32'(exp_dm[n]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    lat, w0, guard;
        string m;

        repeat (3) @(posedge clk);
        #1;
        check("reset ack",       32'(ack), 0);
        check("reset err",       32'(err), 0);
        check("reset mem_we",    32'(bus.mem_we), 0);
        check("reset mem_addr",  32'(bus.mem_addr), 0);
        check("reset mem_wdata", 32'(bus.mem_wdata), 0);
        check("reset ptrn_idx",  32'(ptrn_idx), 'hF);
        @(negedge clk); init = 1'b0;

        // Pattern 0x48, seed 0x01, 35 x '@' after a 10-space preamble.
        set_preamble();
        for (int n = 10; n < 45; n++) plain[n] = 8'h40;
        build(1, 'h01); prep();
        run("t1", 600, lat);
        check("t1 idx literal", 32'(ptrn_idx), 1);
        check("t1 dm9",  32'(dm[9]),  'h00);
        check("t1 dm10", 32'(dm[10]), 'h20);
        check("t1 dm44", 32'(dm[44]), 'h20);
        check("t1 dm45", 32'(dm[45]), 'h00);

        // Pattern 0x60, seed 0x7F, first candidate matches: 148-cycle run.
        set_preamble();
        m = "Mr. Watson, come here.";
        for (int n = 0; n < m.len(); n++) plain[10 + n] = m[n];
        build(0, 'h7F); prep();
        run("t2", 600, lat);
        check("t2 latency literal", lat, 148);
        check("t2 idx literal", 32'(ptrn_idx), 0);
        check("t2 dm10", 32'(dm[10]), 'h2D);

        // No pattern fits: all nine candidates rejected, DM untouched.
        enc[0] = 8'h05;
        for (int n = 1; n < 64; n++) enc[n] = 8'h55;
        prep();
        run("t3", 600, lat);
        check("t3 err literal", 32'(err), 1);
        check("t3 idx literal", 32'(ptrn_idx), 'hF);

        // Zero seed (with and without bit 7 set): DONE two cycles after launch.
        set_preamble(); build(2, 'h33);
        enc[0] = 8'h00; prep();
        run("t4a", 600, lat);
        check("t4a latency literal", lat, 2);
        set_preamble(); build(4, 'h21);
        enc[0] = 8'h80; prep();
        run("t4b", 600, lat);
        check("t4b err literal", 32'(err), 1);

        // init pulsed ~10 cycles into decryption, then a clean rerun.
        set_preamble();
        for (int n = 10; n < 64; n++) plain[n] = 8'($urandom_range('h20, 'h7E));
        build($urandom_range(0, 8), $urandom_range(1, 127)); prep();
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        guard = 0;
        while (bus.mem_we !== 1'b1 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t5 reached decode", 32'(bus.mem_we), 1);
        repeat (10) @(posedge clk);
        #3 init = 1'b1;
        #1;
        check("t5 init ack",      32'(ack), 0);
        check("t5 init err",      32'(err), 0);
        check("t5 init mem_we",   32'(bus.mem_we), 0);
        check("t5 init mem_addr", 32'(bus.mem_addr), 0);
        check("t5 init wdata",    32'(bus.mem_wdata), 0);
        check("t5 init ptrn_idx", 32'(ptrn_idx), 'hF);
        w0 = wr_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk); init = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("t5 no writes after init", wr_cnt - w0, 0);
        check("t5 idle ack", 32'(ack), 0);
        run("t5 rerun", 600, lat);

        // req raised during the pattern search aborts; falling req restarts.
        set_preamble();
        for (int n = 10; n < 64; n++) plain[n] = 8'($urandom_range('h20, 'h7E));
        build($urandom_range(0, 8), $urandom_range(1, 127)); prep();
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); req = 1'b1;
        @(posedge clk); #1;
        check("t6 abort mem_we",   32'(bus.mem_we), 0);
        check("t6 abort mem_addr", 32'(bus.mem_addr), 0);
        check("t6 abort ack",      32'(ack), 0);
        w0 = wr_cnt;
        repeat (5) @(posedge clk); #1;
        check("t6 idle ack",    32'(ack), 0);
        check("t6 idle writes", wr_cnt - w0, 0);
        run("t6 restart", 600, lat);

        // Randomised messages, patterns and seeds.
        for (int r = 0; r < 6; r++) begin
            set_preamble();
            for (int n = 10; n < 64; n++) plain[n] = 8'($urandom_range('h20, 'h7E));
            build($urandom_range(0, 8), $urandom_range(1, 127)); prep();
            run($sformatf("rnd%0d", r), 600, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_decrypt_seq.md
Name: lfsr_decrypt_seq

Overview:
- Hardware sequencer that runs the message-decryption task in place of the software program.
- Owns the data-memory port:
  - recovers the LFSR seed from the first encrypted preamble byte;
  - identifies which of the 9 legal 7-bit tap patterns was used, by checking the following preamble bytes;
  - writes decrypted, space-relative bytes to DM[0..63].
- Sits inside top_level beside DM and is launched by the same req/ack pair.

Parameters:
- CRYPT_BASE, 64: DM address of encrypted byte 0.
- MSG_LEN, 64: bytes decrypted/written.
- PRE_CHECK, 9: preamble bytes (1..PRE_CHECK) verified per candidate pattern; the preamble is guaranteed ≥10.
- AW, 8: DM address width.

Ports:
- clk, input, 1: clock, rising edge.
- init, input, 1: asynchronous active-high reset.
- req, input, 1: high = hold idle; falling edge launches a run.
- ack, output, 1: run complete; held until req is next high.
- mem_addr, output, AW: DM address.
- mem_we, output, 1: DM write enable.
- mem_wdata, output, 8: DM write data.
- mem_rdata, input, 8: DM read data, valid one cycle after mem_addr with mem_we=0.
- err, output, 1: run ended without a valid seed or pattern.
- ptrn_idx, output, 4: index (0..8) of the matched pattern; 4'hF if none.

Behaviour:
- Reset (init=1, async): state IDLE, ack=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, ptrn_idx=4'hF, all counters 0.
- LFSR step: next = {s[5:0], ^(s & ptrn)}. Only bits [6:0] of encrypted bytes participate; bit 7 is ignored unless the optional feature is compiled in.
- States and transitions:
  - IDLE: leave when req was 1 in the previous cycle and is 0 now (registered falling edge). Go to SEED_RD. ack and err cleared on entry.
  - SEED_RD: mem_addr=CRYPT_BASE. Next cycle SEED_CAP.
  - SEED_CAP: seed = mem_rdata[6:0].
    - seed==0: err=1 → DONE.
    - Otherwise p=0, k=1, lfsr=step(seed, PTRN[0]) → CHK_RD.
  - CHK_RD: mem_addr=CRYPT_BASE+k → CHK_CMP.
  - CHK_CMP: compare mem_rdata[6:0] with lfsr.
    - Match with k==PRE_CHECK: ptrn_idx=p, i=0, lfsr=seed → DEC_RD.
    - Match with k<PRE_CHECK: k++, lfsr steps → CHK_RD.
    - Mismatch with p<8: p++, k=1, lfsr=step(seed, PTRN[p+1]) → CHK_RD. Mismatches exit early.
    - Mismatch with p==8: err=1, ptrn_idx=4'hF → DONE. No DM writes occur in this case.
  - DEC_RD: mem_addr=CRYPT_BASE+i → DEC_WR.
  - DEC_WR: mem_addr=i, mem_we=1, mem_wdata={1'b0, mem_rdata[6:0]^lfsr}. lfsr steps.
    - i==MSG_LEN-1 → DONE.
    - Otherwise i++ → DEC_RD.
  - DONE: ack=1, mem_we=0. Stay until req=1, then IDLE.
- Timing:
  - Successful run takes 2 + 2·(compare cycles) + 2·MSG_LEN cycles from launch to ack rising.
  - Pattern 0 matching on first try: 2+18+128 = 148 cycles. Worst case is bounded by 2+162+128.
- mem_we is asserted only in DEC_WR, for exactly 1 cycle per byte.
- ptrn_idx is PTRN index order, not the tap value.
- Boundary and abort cases:
  - req=1 in any non-IDLE state: abort, go to IDLE next cycle, mem_we=0. Partial writes remain in DM.
  - init mid-run: immediate return to reset values. No further writes.
  - Address arithmetic is AW-bit. CRYPT_BASE+MSG_LEN-1 must be ≤ 2^AW-1, enforced by an elaboration-time assertion.

Optional Feature:
- Macro DECRYPT_PARITY_EN.
- Defined:
  - Bit 7 of each encrypted byte is even parity over [6:0].
  - Adds output par_err, 1 bit: sticky, set in DEC_WR when mem_rdata[7] != ^mem_rdata[6:0], cleared on launch.
  - A seed byte with bad parity sets err → DONE.
- Undefined: bit 7 is ignored and there is no par_err port.

Decomposition:
- Package decrypt_pkg:
  - state enum;
  - LFSR_PTRN[9] = {60,48,78,72,6A,69,5C,7E,7B} hex;
  - NUM_PTRN=9;
  - lfsr_step function.
- Sub-module lfsr7: 7-bit register with load/step/ptrn inputs.

Test Plan:
- Pattern 0x48, seed 0x01, 10-byte space preamble, message 35×'@', padded with spaces to 64 bytes → ack, err=0, ptrn_idx=1, DM[0..9]=0x00, DM[10..44]=0x20, DM[45..63]=0x00.
- Pattern 0x60, seed 0x7F, "Mr. Watson, come here." → ptrn_idx=0, ack exactly 148 cycles after req falls, DM[10]=0x2D ('M'-0x20).
- DM[64]=0x05, DM[65..127]=0x55 → err=1, ptrn_idx=4'hF, ack=1, DM[0..63] unchanged.
- DM[64]=0x00 → err=1, DONE 2 cycles after launch, no writes.
- init pulsed 10 cycles into DEC_RD/DEC_WR → outputs return to reset values immediately, no mem_we afterwards. A fresh req low then completes correctly.
- req reasserted mid-search → IDLE next cycle, ack stays 0. Falling req then restarts from SEED_RD.
